controle_de_ciclo: RTL and testbench

CONTROLE_DE_CICLO -- requirements
Module: controle_de_ciclo

---
 rtl/controle_de_ciclo.sv | 130 +++++++++++++
 tb/tb_controle_de_ciclo.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_de_ciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and the branch-unit command, counts retired instructions.
module controle_de_ciclo (
   input  logic        clock,
   input  logic        Reset,
   input  logic [2:0]  classe,
   input  logic        memReady,
   input  logic        continuar,
   output logic [1:0]  comando,
   output logic        pcEnable,
   output logic        irLoad,
   output logic        memRead,
   output logic        memWrite,
   output logic        regWrite,
   output logic        halted,
   output logic        erroInstr,
   output logic [2:0]  estado,
   output logic [15:0] contInstr
);

   typedef enum logic [2:0] {
      BUSCA   = 3'd0,
      DECOD   = 3'd1,
      EXEC    = 3'd2,
      MEMORIA = 3'd3,
      ESCRITA = 3'd4,
      PARADO  = 3'd5
   } estado_t;

   localparam logic [2:0] C_ALU   = 3'd0;
   localparam logic [2:0] C_LOAD  = 3'd1;
   localparam logic [2:0] C_STORE = 3'd2;
   localparam logic [2:0] C_BEQ   = 3'd3;
   localparam logic [2:0] C_JUMP  = 3'd4;
   localparam logic [2:0] C_HALT  = 3'd5;

   estado_t    est_q, est_d;
   logic [2:0] classe_q;
   logic       final_c, ir_c, mr_c, mw_c, rw_c, h_c, er_c;
   logic [1:0] cmd_c;

   always_ff @(posedge clock) begin
      if (Reset) begin
         est_q     <= BUSCA;
         classe_q  <= C_ALU;
         contInstr <= 16'd0;
      end else begin
         est_q <= est_d;
         if (est_q == DECOD) classe_q <= classe;
         if (pcEnable) contInstr <= contInstr + 16'd1;
      end
   end

   // Only the DECOD next-state decision looks at the live classe input;
   // every strobe is derived from the registered class.
   always_comb begin
      est_d   = est_q;
      final_c = 1'b0;
      ir_c    = 1'b0;
      mr_c    = 1'b0;
      mw_c    = 1'b0;
      rw_c    = 1'b0;
      h_c     = 1'b0;
      er_c    = 1'b0;
      case (est_q)
         BUSCA: begin
            mr_c = 1'b1;
            ir_c = memReady;
            if (memReady) est_d = DECOD;
         end
         DECOD: est_d = (classe == C_HALT) ? PARADO : EXEC;
         EXEC: begin
            if (classe_q == C_LOAD || classe_q == C_STORE) begin
               est_d = MEMORIA;
            end else if (classe_q == C_ALU) begin
               est_d = ESCRITA;
            end else begin
               est_d   = BUSCA;
               final_c = 1'b1;
               er_c    = classe_q[2] & classe_q[1];
            end
         end
         MEMORIA: begin
            mr_c = (classe_q == C_LOAD);
            mw_c = (classe_q == C_STORE);
            if (memReady) begin
               if (classe_q == C_LOAD) begin
                  est_d = ESCRITA;
               end else begin
                  est_d   = BUSCA;
                  final_c = 1'b1;
               end
            end
         end
         ESCRITA: begin
            rw_c    = (classe_q == C_ALU) || (classe_q == C_LOAD);
            final_c = 1'b1;
            est_d   = BUSCA;
         end
         PARADO: begin
            h_c = 1'b1;
            if (continuar) begin
               final_c = 1'b1;
               est_d   = BUSCA;
            end
         end
         default: est_d = BUSCA;
      endcase

      if (!final_c)                cmd_c = 2'b11;
      else if (classe_q == C_BEQ)  cmd_c = 2'b01;
      else if (classe_q == C_JUMP) cmd_c = 2'b10;
      else                         cmd_c = 2'b00;
   end

   // Reset masks every strobe so nothing fires while the state is being forced.
   always_comb begin
      pcEnable  = final_c & ~Reset;
      irLoad    = ir_c & ~Reset;
      memRead   = mr_c & ~Reset;
      memWrite  = mw_c & ~Reset;
      regWrite  = rw_c & ~Reset;
      halted    = h_c & ~Reset;
      erroInstr = er_c & ~Reset;
      comando   = Reset ? 2'b11 : cmd_c;
   end

   assign estado = est_q;

endmodule

// File: tb/tb_controle_de_ciclo.sv
// Self-checking bench for controle_de_ciclo: directed scenarios plus random
// instruction streams against a per-instruction cycle-sequence model.
module tb_controle_de_ciclo;

   logic        clock = 1'b0;
   logic        Reset;
   logic [2:0]  classe;
   logic        memReady, continuar;
   logic [1:0]  comando;
   logic        pcEnable, irLoad, memRead, memWrite, regWrite, halted, erroInstr;
   logic [2:0]  estado;
   logic [15:0] contInstr;

   controle_de_ciclo dut (
      .clock(clock), .Reset(Reset), .classe(classe), .memReady(memReady),
      .continuar(continuar), .comando(comando), .pcEnable(pcEnable),
      .irLoad(irLoad), .memRead(memRead), .memWrite(memWrite),
      .regWrite(regWrite), .halted(halted), .erroInstr(erroInstr),
      .estado(estado), .contInstr(contInstr)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] est;
      logic [1:0] cmd;
      logic pc, ir, mr, mw, rw, h, er;
   } obs_t;

   typedef struct packed {
      logic rdy, cont;
      logic [2:0] cls;
   } stim_t;

   stim_t       sq[$];
   obs_t        eq[$], aq[$];
   logic [15:0] cq[$], acq[$];
   logic [15:0] m_cnt;
   int          n_cmp = 0;
   int          n_fail = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: expected cycles of one instruction
   task automatic push(input logic [2:0] est, input logic [1:0] cmd,
                       input logic pc, ir, mr, mw, rw, h, er,
                       input logic rdy, cont, input logic [2:0] cls);
      obs_t o;
      stim_t s;
      o = '{est: est, cmd: cmd, pc: pc, ir: ir, mr: mr, mw: mw, rw: rw, h: h, er: er};
      s = '{rdy: rdy, cont: cont, cls: cls};
      sq.push_back(s);
      eq.push_back(o);
      cq.push_back(m_cnt);
      if (pc) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic add_instr(input logic [2:0] cls, input int bw, input int mw, input int hw);
      logic       fin, st_fin;
      logic [1:0] cf;
      for (int i = 0; i <= bw; i++)
         push(3'd0, 2'b11, 1'b0, (i == bw), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              (i == bw), 1'($urandom), 3'($urandom));
      push(3'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'($urandom), 1'($urandom), cls);
      if (cls == 3'd5) begin
         for (int i = 0; i <= hw; i++)
            push(3'd5, (i == hw) ? 2'b00 : 2'b11, (i == hw), 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'($urandom), (i == hw), 3'($urandom));
         return;
      end
      fin = (cls == 3'd3) || (cls == 3'd4) || (cls >= 3'd6);
      cf  = (cls == 3'd3) ? 2'b01 : (cls == 3'd4) ? 2'b10 : 2'b00;
      push(3'd2, fin ? cf : 2'b11, fin, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (cls >= 3'd6),
           1'($urandom), 1'($urandom), 3'($urandom));
      if (cls == 3'd1 || cls == 3'd2)
         for (int i = 0; i <= mw; i++) begin
            st_fin = (cls == 3'd2) && (i == mw);
            push(3'd3, st_fin ? 2'b00 : 2'b11, st_fin, 1'b0, (cls == 3'd1), (cls == 3'd2),
                 1'b0, 1'b0, 1'b0, (i == mw), 1'($urandom), 3'($urandom));
         end
      if (cls == 3'd0 || cls == 3'd1)
         push(3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1'($urandom), 1'($urandom), 3'($urandom));
   endtask

   // ---------------- stimulus plumbing (no checking here)
   task automatic clear_model();
      sq.delete();
      eq.delete();
      cq.delete();
   endtask

   task automatic run_queue();
      obs_t a;
      aq.delete();
      acq.delete();
      foreach (sq[i]) begin
         memReady  = sq[i].rdy;
         continuar = sq[i].cont;
         classe    = sq[i].cls;
         @(negedge clock);
         a = '{est: estado, cmd: comando, pc: pcEnable, ir: irLoad, mr: memRead,
               mw: memWrite, rw: regWrite, h: halted, er: erroInstr};
         aq.push_back(a);
         acq.push_back(contInstr);
         @(posedge clock);
         #1;
      end
      memReady  = 1'b0;
      continuar = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      memReady = 1'b0;
      continuar = 1'b0;
      @(posedge clock);
      #1;
      Reset = 1'b0;
      m_cnt = 16'd0;
   endtask

   // ---------------- tests
   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         memReady  = 1'($urandom);
         continuar = 1'($urandom);
         classe    = 3'($urandom);
         @(negedge clock);
         n_cmp++;
         if ({estado, comando, pcEnable, irLoad, memWrite, regWrite, halted, erroInstr, contInstr}
             !== {3'd0, 2'b11, 6'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: est=%0d cmd=%b pc=%b ir=%b mw=%b rw=%b h=%b er=%b cnt=%0d, want est=0 cmd=11 strobes 0 cnt=0",
                     i, estado, comando, pcEnable, irLoad, memWrite, regWrite, halted, erroInstr, contInstr);
         end
         @(posedge clock);
         #1;
      end
      Reset = 1'b0;
      memReady = 1'b0;
      continuar = 1'b0;
      m_cnt = 16'd0;
      @(negedge clock);
      n_cmp++;
      if ({estado, memRead, irLoad, comando, contInstr} !== {3'd0, 1'b1, 1'b0, 2'b11, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_release: est=%0d memRead=%b irLoad=%b cmd=%b cnt=%0d, want est=0 memRead=1 irLoad=0 cmd=11 cnt=0",
                  estado, memRead, irLoad, comando, contInstr);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_alu();
      do_reset();
      clear_model();
      add_instr(3'd0, 0, 0, 0);
      run_queue();
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL alu cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
      end
      @(negedge clock);
      n_cmp++;
      if (contInstr !== 16'd1) begin
         n_fail++;
         $display("FAIL alu_count: got %0d, want 1", contInstr);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_load_wait();
      int mem_rd;
      clear_model();
      add_instr(3'd1, 0, 2, 0);
      run_queue();
      mem_rd = 0;
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL load_wait cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
         if (aq[i].est == 3'd3 && aq[i].mr) mem_rd++;
      end
      n_cmp++;
      if (mem_rd != 3) begin
         n_fail++;
         $display("FAIL load_memread_cycles: got %0d, want 3", mem_rd);
      end
   endtask

   task automatic test_branch_jump();
      do_reset();
      clear_model();
      add_instr(3'd3, 0, 0, 0);
      add_instr(3'd4, 0, 0, 0);
      run_queue();
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL branch_jump cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
      end
      @(negedge clock);
      n_cmp++;
      if (contInstr !== 16'd2) begin
         n_fail++;
         $display("FAIL branch_jump_count: got %0d, want 2", contInstr);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_halt();
      int nh;
      clear_model();
      add_instr(3'd5, 1, 0, 5);
      add_instr(3'd0, 0, 0, 0);
      run_queue();
      nh = 0;
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL halt cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
         if (aq[i].h) nh++;
      end
      n_cmp++;
      if (nh != 6) begin
         n_fail++;
         $display("FAIL halt_cycles: got %0d, want 6", nh);
      end
   endtask

   task automatic test_illegal();
      int nrw, ner;
      clear_model();
      add_instr(3'd7, 0, 0, 0);
      add_instr(3'd6, 2, 0, 0);
      run_queue();
      nrw = 0;
      ner = 0;
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL illegal cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
         if (aq[i].rw) nrw++;
         if (aq[i].er) ner++;
      end
      n_cmp++;
      if (nrw != 0 || ner != 2) begin
         n_fail++;
         $display("FAIL illegal_strobes: regWrite cycles %0d erroInstr pulses %0d, want 0 and 2", nrw, ner);
      end
   endtask

   task automatic test_reset_in_mem();
      clear_model();
      add_instr(3'd0, 0, 0, 0);
      run_queue();
      memReady = 1'b1;
      classe = 3'($urandom);
      @(posedge clock);
      #1;
      classe = 3'd2;
      memReady = 1'b0;
      @(posedge clock);
      #1;
      classe = 3'($urandom);
      memReady = 1'($urandom);
      @(posedge clock);
      #1;
      Reset = 1'b1;
      memReady = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({estado, pcEnable, memWrite, comando} !== {3'd3, 1'b0, 1'b0, 2'b11}) begin
         n_fail++;
         $display("FAIL reset_in_mem: est=%0d pc=%b mw=%b cmd=%b, want est=3 pc=0 mw=0 cmd=11",
                  estado, pcEnable, memWrite, comando);
      end
      @(posedge clock);
      #1;
      Reset = 1'b0;
      memReady = 1'b0;
      m_cnt = 16'd0;
      @(negedge clock);
      n_cmp++;
      if ({estado, contInstr, memRead} !== {3'd0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_in_mem_after: est=%0d cnt=%0d memRead=%b, want est=0 cnt=0 memRead=1",
                  estado, contInstr, memRead);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      clear_model();
      for (int k = 0; k < 80; k++)
         add_instr(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4));
      run_queue();
      foreach (eq[i]) begin
         n_cmp++;
         if (aq[i] !== eq[i] || acq[i] !== cq[i]) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %b cnt %0d, want %b cnt %0d", i, aq[i], acq[i], eq[i], cq[i]);
         end
      end
      @(negedge clock);
      n_cmp++;
      if (contInstr !== m_cnt) begin
         n_fail++;
         $display("FAIL random_count: got %0d, want %0d", contInstr, m_cnt);
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      memReady = 1'b0;
      continuar = 1'b0;
      classe = 3'd0;
      m_cnt = 16'd0;
      test_reset();
      test_alu();
      test_load_wait();
      test_branch_jump();
      test_halt();
      test_illegal();
      test_reset_in_mem();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
